// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt-controller IRR/priority slice:
// IR count, spurious vector number, acknowledge state enum and a rank helper.
package pic_pkg;

    localparam int NUM_IR = 8;
    localparam int ID_W   = 3;
    localparam logic [ID_W-1:0] SPURIOUS_ID = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } ack_state_t;

    // Rank 0 is the highest priority: the IR just above the lowest-priority pointer.
    function automatic logic [ID_W-1:0] prio_rank(input logic [ID_W-1:0] id,
                                                 input logic [ID_W-1:0] prio_low);
        return id - prio_low - 3'd1;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority picker: returns the highest-priority set bit
// of req, where priority descends from prio_low+1 around to prio_low.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] req,
    input  logic [ID_W-1:0]   prio_low,
    output logic              valid,
    output logic [ID_W-1:0]   id
);

    logic [2*NUM_IR-1:0] doubled;
    logic [NUM_IR-1:0]   rotated;
    logic [3:0]          start;
    logic [ID_W-1:0]     offset;

    // Rotate so that bit 0 is the top-priority IR, then take the lowest set bit.
    always_comb begin
        doubled = {req, req};
        start   = {1'b0, prio_low} + 4'd1;
        rotated = doubled[start +: NUM_IR];
        valid   = |rotated;
        offset  = '0;
        for (int k = NUM_IR - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = k[ID_W-1:0];
            end
        end
        id = prio_low + 3'd1 + offset;
    end

endmodule

// File: rtl/pic_irr_resolver.sv
// Interrupt request register with edge/level capture, rotating priority,
// ISR-aware INT generation and the two-pulse INTA acknowledge sequence.
module pic_irr_resolver
    import pic_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_IR-1:0] ir_in,
    input  logic              level_mode,
    input  logic [NUM_IR-1:0] imr,
    input  logic [NUM_IR-1:0] isr,
    input  logic              inta_pulse,
    input  logic              rotate_en,
    input  logic              eoi_pulse,
    input  logic [ID_W-1:0]   eoi_id,
    output logic [NUM_IR-1:0] irr,
    output logic              int_req,
    output logic [NUM_IR-1:0] set_isr,
    output logic [ID_W-1:0]   vector_id,
    output logic              vector_valid,
    output logic              spurious
);

    ack_state_t        state;
    ack_state_t        state_next;
    logic [NUM_IR-1:0] ir_prev;
    logic [ID_W-1:0]   prio_low;

    logic              win_valid;
    logic [ID_W-1:0]   win_id;
    logic [NUM_IR-1:0] win_onehot;
    logic              isr_valid;
    logic [ID_W-1:0]   isr_id;

    logic [NUM_IR-1:0] ack_clear;
    logic [NUM_IR-1:0] irr_next;
    logic              int_req_next;
    logic [NUM_IR-1:0] set_isr_next;
    logic [ID_W-1:0]   vector_id_next;
    logic              vector_valid_next;
    logic              spurious_next;

    pic_priority_resolver u_req_resolver (
        .req      (irr & ~imr),
        .prio_low (prio_low),
        .valid    (win_valid),
        .id       (win_id)
    );

    pic_priority_resolver u_isr_resolver (
        .req      (isr),
        .prio_low (prio_low),
        .valid    (isr_valid),
        .id       (isr_id)
    );

    assign win_onehot = NUM_IR'(1) << win_id;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        set_isr_next      = '0;
        vector_id_next    = vector_id;
        vector_valid_next = 1'b0;
        spurious_next     = spurious;
        ack_clear         = '0;
        case (state)
            IDLE: begin
                if (inta_pulse) begin
                    state_next = ACK1;
                    if (win_valid) begin
                        vector_id_next = win_id;
                        set_isr_next   = win_onehot;
                        ack_clear      = level_mode ? '0 : win_onehot;
                        spurious_next  = 1'b0;
                    end else begin
                        vector_id_next = SPURIOUS_ID;
                        spurious_next  = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_pulse) begin
                    state_next        = ACK2;
                    vector_valid_next = 1'b1;
                end
            end
            ACK2: begin
                state_next    = IDLE;
                spurious_next = 1'b0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // INT only from IDLE, and only when the winner outranks everything in service.
        int_req_next = (state == IDLE) && !inta_pulse && win_valid &&
                       (!isr_valid ||
                        (prio_rank(win_id, prio_low) < prio_rank(isr_id, prio_low)));
    end

    // In edge mode the acknowledge clear is applied last so it beats a same-cycle set.
    always_comb begin
        if (level_mode) begin
            irr_next = ir_in;
        end else begin
            irr_next = (irr | (ir_in & ~ir_prev)) & ir_in & ~ack_clear;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irr          <= '0;
            ir_prev      <= '0;
            prio_low     <= 3'd7;
            int_req      <= 1'b0;
            set_isr      <= '0;
            vector_id    <= '0;
            vector_valid <= 1'b0;
            spurious     <= 1'b0;
        end else begin
            irr          <= irr_next;
            ir_prev      <= ir_in;
            int_req      <= int_req_next;
            set_isr      <= set_isr_next;
            vector_id    <= vector_id_next;
            vector_valid <= vector_valid_next;
            spurious     <= spurious_next;
            if (eoi_pulse && rotate_en) begin
                prio_low <= eoi_id;
            end
        end
    end

endmodule

// File: tb/tb_pic_irr_resolver.sv
// Scoreboard bench for pic_irr_resolver: a behavioural model predicts every
// cycle's outputs and each completed acknowledge; a monitor compares them.
module tb_pic_irr_resolver;

    logic       clk;
    logic       reset_n;
    logic [7:0] ir_in;
    logic       level_mode;
    logic [7:0] imr;
    logic [7:0] isr;
    logic       inta_pulse;
    logic       rotate_en;
    logic       eoi_pulse;
    logic [2:0] eoi_id;
    logic [7:0] irr;
    logic       int_req;
    logic [7:0] set_isr;
    logic [2:0] vector_id;
    logic       vector_valid;
    logic       spurious;

    typedef struct packed {
        logic [7:0] irr;
        logic       int_req;
        logic [7:0] set_isr;
        logic [2:0] vector_id;
        logic       vector_valid;
        logic       spurious;
    } exp_t;

    typedef struct packed {
        logic [2:0] id;
        logic       spur;
    } ack_t;

    exp_t q_cycle[$];
    ack_t q_ack[$];
    int   checks = 0;
    int   errors = 0;

    bit [7:0] m_irr   = '0;
    bit [7:0] m_prev  = '0;
    int       m_plow  = 7;
    int       m_phase = 0;
    bit [2:0] m_vid   = '0;
    bit       m_spur  = 1'b0;
    bit       m_intreq = 1'b0;

    pic_irr_resolver dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ir_in        (ir_in),
        .level_mode   (level_mode),
        .imr          (imr),
        .isr          (isr),
        .inta_pulse   (inta_pulse),
        .rotate_en    (rotate_en),
        .eoi_pulse    (eoi_pulse),
        .eoi_id       (eoi_id),
        .irr          (irr),
        .int_req      (int_req),
        .set_isr      (set_isr),
        .vector_id    (vector_id),
        .vector_valid (vector_valid),
        .spurious     (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Position in the priority order: 0 is the IR right after the lowest-priority one.
    function automatic int rank(input int id, input int plow);
        return (id - plow - 1 + 16) % 8;
    endfunction

    function automatic void pick(input bit [7:0] v, input int plow, output bit ok, output int id);
        ok = 1'b0;
        id = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i] && (!ok || rank(i, plow) < rank(id, plow))) begin
                ok = 1'b1;
                id = i;
            end
        end
    endfunction

    task automatic model_step();
        exp_t     e;
        ack_t     a;
        bit       wv, iv, vv, nreq;
        int       wid, iid;
        bit [7:0] clr, set_n;
        clr   = '0;
        set_n = '0;
        vv    = 1'b0;
        if (reset_n !== 1'b1) begin
            m_irr = '0; m_prev = '0; m_plow = 7; m_phase = 0;
            m_vid = '0; m_spur = 1'b0; m_intreq = 1'b0;
        end else begin
            pick(m_irr & ~imr, m_plow, wv, wid);
            pick(isr, m_plow, iv, iid);
            nreq = (m_phase == 0) && !inta_pulse && wv &&
                   (!iv || rank(wid, m_plow) < rank(iid, m_plow));
            if (m_phase == 0) begin
                if (inta_pulse) begin
                    m_phase = 1;
                    if (wv) begin
                        m_vid  = 3'(wid);
                        set_n  = 8'(1) << wid;
                        if (!level_mode) clr = set_n;
                        m_spur = 1'b0;
                    end else begin
                        m_vid  = 3'd7;
                        m_spur = 1'b1;
                    end
                end
            end else if (m_phase == 1) begin
                if (inta_pulse) begin
                    m_phase = 2;
                    vv      = 1'b1;
                    a.id    = m_vid;
                    a.spur  = m_spur;
                    q_ack.push_back(a);
                end
            end else begin
                m_phase = 0;
                m_spur  = 1'b0;
            end
            if (level_mode) m_irr = ir_in;
            else            m_irr = (m_irr | (ir_in & ~m_prev)) & ir_in & ~clr;
            m_prev = ir_in;
            if (eoi_pulse && rotate_en) m_plow = int'(eoi_id);
            m_intreq = nreq;
        end
        e.irr          = m_irr;
        e.int_req      = m_intreq;
        e.set_isr      = set_n;
        e.vector_id    = m_vid;
        e.vector_valid = vv;
        e.spurious     = m_spur;
        q_cycle.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        model_step();
    end

    always @(posedge clk) begin
        exp_t e;
        exp_t got;
        ack_t a;
        #2;
        got = {irr, int_req, set_isr, vector_id, vector_valid, spurious};
        checks++;
        if (q_cycle.size() == 0) begin
            errors++;
            $display("[TB] FAIL cycle_queue_empty at %0t", $time);
        end else begin
            e = q_cycle.pop_front();
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL cycle_outputs at %0t: got irr=%h int=%b set=%h vid=%0d vv=%b sp=%b, expected irr=%h int=%b set=%h vid=%0d vv=%b sp=%b",
                         $time, irr, int_req, set_isr, vector_id, vector_valid, spurious,
                         e.irr, e.int_req, e.set_isr, e.vector_id, e.vector_valid, e.spurious);
            end
        end
        if (vector_valid === 1'b1) begin
            checks++;
            if (q_ack.size() == 0) begin
                errors++;
                $display("[TB] FAIL ack_unexpected at %0t: got vector_valid=1 vid=%0d, expected no acknowledge", $time, vector_id);
            end else begin
                a = q_ack.pop_front();
                if (vector_id !== a.id || spurious !== a.spur) begin
                    errors++;
                    $display("[TB] FAIL ack_vector at %0t: got vid=%0d sp=%b, expected vid=%0d sp=%b",
                             $time, vector_id, spurious, a.id, a.spur);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] ir, input logic lvl, input logic [7:0] mask, input logic [7:0] ins);
        ir_in      = ir;
        level_mode = lvl;
        imr        = mask;
        isr        = ins;
    endtask

    task automatic pulse_inta();
        inta_pulse = 1'b1;
        tick(1);
        inta_pulse = 1'b0;
    endtask

    task automatic pulse_eoi(input logic [2:0] id);
        eoi_pulse = 1'b1;
        rotate_en = 1'b1;
        eoi_id    = id;
        tick(1);
        eoi_pulse = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; inta_pulse = 1'b0; eoi_pulse = 1'b0; rotate_en = 1'b0; eoi_id = '0;
        applyStimulus(8'h00, 1'b0, 8'h00, 8'h00);
        tick(3);
        checkOutput("reset_irr", irr, 8'h00);
        checkOutput("reset_vector_id", {5'b0, vector_id}, 8'h00);
        reset_n = 1'b1;
        tick(2);

        // Basic edge-mode request and full acknowledge of IR2.
        applyStimulus(8'h04, 1'b0, 8'h00, 8'h00);
        tick(2);
        checkOutput("edge_irr_set", irr, 8'h04);
        checkOutput("edge_int_req", {7'b0, int_req}, 8'h01);
        pulse_inta();
        checkOutput("ack1_set_isr", set_isr, 8'h04);
        checkOutput("ack1_vector_id", {5'b0, vector_id}, 8'h02);
        checkOutput("ack1_irr_clear", irr, 8'h00);
        checkOutput("ack1_int_drop", {7'b0, int_req}, 8'h00);
        tick(1);
        checkOutput("ack1_set_isr_once", set_isr, 8'h00);
        pulse_inta();
        checkOutput("ack2_vector_valid", {7'b0, vector_valid}, 8'h01);
        tick(1);
        checkOutput("ack2_valid_one_cycle", {7'b0, vector_valid}, 8'h00);
        applyStimulus(8'h00, 1'b0, 8'h00, 8'h00);
        tick(2);

        // IR0 beats IR7 by default; rotating on IR0 then hands IR7 the win.
        applyStimulus(8'h81, 1'b0, 8'h00, 8'h00);
        tick(2);
        pulse_inta();
        checkOutput("default_prio_vid", {5'b0, vector_id}, 8'h00);
        tick(1);
        pulse_inta();
        tick(1);
        pulse_eoi(3'd0);
        tick(1);
        pulse_inta();
        checkOutput("rotated_vid", {5'b0, vector_id}, 8'h07);
        checkOutput("rotated_set_isr", set_isr, 8'h80);
        tick(1);
        pulse_inta();
        tick(1);
        pulse_eoi(3'd7);
        applyStimulus(8'h00, 1'b0, 8'h00, 8'h00);
        tick(2);

        // In-service blocking: only a strictly higher priority request raises INT.
        applyStimulus(8'h02, 1'b0, 8'h00, 8'h01);
        tick(3);
        checkOutput("isr_blocks_int", {7'b0, int_req}, 8'h00);
        applyStimulus(8'h02, 1'b0, 8'h00, 8'h04);
        tick(2);
        checkOutput("isr_allows_int", {7'b0, int_req}, 8'h01);
        applyStimulus(8'h00, 1'b0, 8'h00, 8'h00);
        tick(3);

        // Request withdrawn before acknowledge gives a spurious vector.
        applyStimulus(8'h10, 1'b0, 8'h00, 8'h00);
        tick(1);
        applyStimulus(8'h00, 1'b0, 8'h00, 8'h00);
        tick(2);
        pulse_inta();
        checkOutput("spurious_flag", {7'b0, spurious}, 8'h01);
        checkOutput("spurious_vid", {5'b0, vector_id}, 8'h07);
        checkOutput("spurious_no_set", set_isr, 8'h00);
        tick(1);
        pulse_inta();
        checkOutput("spurious_held_ack2", {7'b0, spurious}, 8'h01);
        tick(1);
        checkOutput("spurious_cleared", {7'b0, spurious}, 8'h00);
        tick(1);

        // EOI rotation coinciding with the first INTA uses the old pointer.
        applyStimulus(8'h03, 1'b0, 8'h00, 8'h00);
        tick(2);
        inta_pulse = 1'b1; eoi_pulse = 1'b1; rotate_en = 1'b1; eoi_id = 3'd0;
        tick(1);
        inta_pulse = 1'b0; eoi_pulse = 1'b0;
        checkOutput("eoi_inta_same_cycle_vid", {5'b0, vector_id}, 8'h00);
        tick(1);
        pulse_inta();
        tick(1);
        pulse_eoi(3'd7);
        applyStimulus(8'h00, 1'b0, 8'h00, 8'h00);
        tick(2);

        // Level mode reasserts after acknowledge; reset in ACK1 abandons the sequence.
        applyStimulus(8'h08, 1'b1, 8'h00, 8'h00);
        tick(2);
        pulse_inta();
        checkOutput("level_set_isr", set_isr, 8'h08);
        checkOutput("level_irr_kept", irr, 8'h08);
        tick(1);
        pulse_inta();
        tick(2);
        checkOutput("level_int_reassert", {7'b0, int_req}, 8'h01);
        pulse_inta();
        reset_n = 1'b0;
        #1;
        checkOutput("midack_reset_set_isr", set_isr, 8'h00);
        checkOutput("midack_reset_vid", {5'b0, vector_id}, 8'h00);
        checkOutput("midack_reset_irr", irr, 8'h00);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        pulse_inta();
        checkOutput("post_reset_no_valid", {7'b0, vector_valid}, 8'h00);
        applyStimulus(8'h00, 1'b0, 8'h00, 8'h00);
        tick(3);

        // Randomized traffic; the model and monitor check every cycle.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(99) < 30) ir_in = ir_in ^ (8'(1) << $urandom_range(7));
            if ($urandom_range(99) < 2)  level_mode = ~level_mode;
            if ($urandom_range(99) < 5)  imr = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(99) < 5)  isr = ($urandom_range(2) == 0) ? 8'($urandom) : 8'h00;
            inta_pulse = ($urandom_range(99) < 15);
            eoi_pulse  = ($urandom_range(99) < 8);
            rotate_en  = $urandom_range(1) == 1;
            eoi_id     = 3'($urandom_range(7));
            reset_n    = ($urandom_range(199) != 0);
            tick(1);
        end
        reset_n = 1'b1; inta_pulse = 1'b0; eoi_pulse = 1'b0;
        tick(4);

        checks++;
        if (q_ack.size() != 0) begin
            errors++;
            $display("[TB] FAIL ack_queue_drain: got %0d pending acknowledges, expected 0", q_ack.size());
        end
        checks++;
        if (q_cycle.size() != 0) begin
            errors++;
            $display("[TB] FAIL cycle_queue_drain: got %0d pending cycles, expected 0", q_cycle.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pic_irr_resolver.md
PIC_IRR_RESOLVER -- requirements
Module: pic_irr_resolver

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: ir_in  in  8  interrupt request lines IR0..IR7, already synchronous to clk.
REQ-004 SHALL have ports: level_mode  in  1  1 = level-triggered IRR, 0 = edge-triggered.
REQ-005 SHALL have ports: imr  in  8  interrupt mask; bit = 1 masks that IR.
REQ-006 SHALL have ports: isr  in  8  current in-service register from the downstream ISR stage.
REQ-007 SHALL have ports: inta_pulse  in  1  one-cycle strobe per INTA# falling edge.
REQ-008 SHALL have ports: rotate_en  in  1  automatic rotation on EOI enabled.
REQ-009 SHALL have ports: eoi_pulse  in  1 / eoi_id  in  3  one-cycle EOI strobe and the IR number being retired.
REQ-010 SHALL have ports: irr  out  8  interrupt request register.
REQ-011 SHALL have ports: int_req  out  1  INT to CPU; set_isr  out  8  one-hot, one-cycle set strobe to ISR stage.
REQ-012 SHALL have ports: vector_id  out  3  acknowledged IR number; vector_valid  out  1; spurious  out  1.

Function
REQ-013 Edge mode: irr[n] SHALL set on the cycle ir_in[n] is high after having been sampled low the previous cycle; it SHALL clear when ir_in[n] is sampled low or when it is acknowledged.
REQ-014 Level mode: irr[n] SHALL equal the registered ir_in[n], and is not cleared by acknowledge.
REQ-015 Priority: pointer prio_low (3 bits) names the lowest-priority IR; priority SHALL descend from (prio_low+1) mod 8 through prio_low, wrapping mod 8.
REQ-016 Winner SHALL be the highest-priority bit of irr & ~imr; int_req SHALL be 1 (registered, 1-cycle latency) iff a winner exists and has strictly higher priority than every set isr bit, or isr = 0.
REQ-017 Ack FSM states: IDLE, ACK1, ACK2.
REQ-018 IDLE -> ACK1 on inta_pulse: latch winner into vector_id, pulse set_isr[winner] for one cycle, clear irr[winner] (edge mode), drop int_req.
REQ-019 If no winner exists at the first inta_pulse: vector_id SHALL be 7, set_isr SHALL stay 0, spurious SHALL be 1 until returning to IDLE.
REQ-020 ACK1 -> ACK2 on second inta_pulse: vector_valid SHALL be 1 for that one cycle; ACK2 -> IDLE on the next cycle unconditionally.
REQ-021 int_req SHALL remain 0 while in ACK1/ACK2; the winner is not re-evaluated mid-sequence.
REQ-022 eoi_pulse with rotate_en = 1 SHALL load prio_low <= eoi_id next cycle; with rotate_en = 0 prio_low SHALL be unchanged.
REQ-023 Simultaneous eoi_pulse and first inta_pulse: winner uses the pre-rotation prio_low.
REQ-024 Simultaneous edge set and ack clear on the same bit: the clear SHALL win.
REQ-025 A masked IR SHALL still latch in irr but never win.

Reset
REQ-026 reset_n low SHALL asynchronously force irr = 0, edge history = 0, prio_low = 7 (IR0 highest), FSM = IDLE, int_req = 0, set_isr = 0, vector_id = 0, vector_valid = 0, spurious = 0.
REQ-027 Reset asserted mid-acknowledge SHALL abandon the sequence with no set_isr or vector_valid emitted.

Structure
REQ-028 Shared package pic_pkg SHALL hold NUM_IR = 8, SPURIOUS_ID = 7, and the ack state enum.
REQ-029 A combinational sub-module pic_priority_resolver (request vector + prio_low -> valid, id) SHALL be instantiated twice: once for irr & ~imr, once for isr.

Verification
REQ-030 Edge mode, ir_in = 0x04 rising, imr = 0, isr = 0 -> irr = 0x04, int_req = 1 one cycle later; two inta_pulses -> set_isr = 0x04 once, vector_id = 2, vector_valid pulse, irr = 0.
REQ-031 ir_in = 0x81, prio_low = 7 -> vector_id = 0; after EOI with eoi_id = 0 and rotate_en = 1 -> the next ack yields vector_id = 7.
REQ-032 isr = 0x01, ir_in = 0x02 -> int_req stays 0; isr = 0x04, ir_in = 0x02 -> int_req = 1.
REQ-033 Edge mode: ir_in = 0x10 rises, then falls before inta_pulse -> first inta_pulse gives spurious = 1, vector_id = 7, set_isr = 0.
REQ-034 Level mode: ir_in = 0x08 held, full ack, isr stays 0 -> int_req reasserts; reset_n pulsed in ACK1 -> all outputs return to reset values with no vector_valid.
